// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC register, redirect/flush control and event counters
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       NextType,
    input  logic [31:0]      IDEXPC4,
    input  logic [31:0]      JumpPC,
    input  logic             BranchPredTaken,
    input  logic [31:0]      BranchTarget,
    input  logic             Stall,
    output logic [31:0]      PC,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             FetchValid,
    output logic             Redirecting,
    output logic [CNT_W-1:0] MispredictCnt,
    output logic [CNT_W-1:0] JumpCnt
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_mis_cnt;
    logic [CNT_W-1:0] r_jmp_cnt;

    logic             w_run;
    logic             w_mis;
    logic             w_jmp;
    logic             w_redirect;
    logic [31:0]      w_next_pc;
    logic [1:0]       w_next_state;

    // Redirects are only honoured in RUN; in REDIR the EX stage holds a bubble.
    assign w_run      = (r_state == S_RUN);
    assign w_mis      = w_run && (NextType == 2'b01);
    assign w_jmp      = w_run && (NextType == 2'b10);
    assign w_redirect = w_mis || w_jmp;

    always_comb begin
        w_next_pc = r_pc;
        if (r_state == S_BOOT) begin
            w_next_pc = r_pc;
        end else if (w_mis) begin
            w_next_pc = IDEXPC4;
        end else if (w_jmp) begin
            w_next_pc = JumpPC;
        end else if (Stall) begin
            w_next_pc = r_pc;
        end else if (BranchPredTaken) begin
            w_next_pc = BranchTarget;
        end else begin
            w_next_pc = r_pc + 32'd4;
        end
    end

    always_comb begin
        w_next_state = S_BOOT;
        case (r_state)
            S_BOOT:  w_next_state = S_RUN;
            S_RUN:   w_next_state = w_redirect ? S_REDIR : S_RUN;
            S_REDIR: w_next_state = S_RUN;
            default: w_next_state = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_mis_cnt <= '0;
            r_jmp_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_mis && (r_mis_cnt != CNT_MAX)) begin
                r_mis_cnt <= r_mis_cnt + 1'b1;
            end
            if (w_jmp && (r_jmp_cnt != CNT_MAX)) begin
                r_jmp_cnt <= r_jmp_cnt + 1'b1;
            end
        end
    end

    assign PC            = r_pc;
    assign IFIDFlush     = w_redirect;
    assign IDEXFlush     = w_redirect;
    assign FetchValid    = (r_state != S_BOOT);
    assign Redirecting   = (r_state == S_REDIR);
    assign MispredictCnt = r_mis_cnt;
    assign JumpCnt       = r_jmp_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic [1:0]    NextType;
    logic [31:0]   IDEXPC4;
    logic [31:0]   JumpPC;
    logic          BranchPredTaken;
    logic [31:0]   BranchTarget;
    logic          Stall;
    logic [31:0]   PC;
    logic          IFIDFlush;
    logic          IDEXFlush;
    logic          FetchValid;
    logic          Redirecting;
    logic [CW-1:0] MispredictCnt;
    logic [CW-1:0] JumpCnt;

    int n_checks = 0;
    int n_pass   = 0;

    pc_redirect_ctrl #(
        .RESET_PC (32'h0000_3000),
        .CNT_W    (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .NextType        (NextType),
        .IDEXPC4         (IDEXPC4),
        .JumpPC          (JumpPC),
        .BranchPredTaken (BranchPredTaken),
        .BranchTarget    (BranchTarget),
        .Stall           (Stall),
        .PC              (PC),
        .IFIDFlush       (IFIDFlush),
        .IDEXFlush       (IDEXFlush),
        .FetchValid      (FetchValid),
        .Redirecting     (Redirecting),
        .MispredictCnt   (MispredictCnt),
        .JumpCnt         (JumpCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; NextType = 2'b00; IDEXPC4 = '0; JumpPC = '0;
        BranchPredTaken = 1'b0; BranchTarget = '0; Stall = 1'b0;

        tick();
        chk("rst1_pc", PC, 32'h3000);
        chk("rst1_fv", {31'd0, FetchValid}, 32'd0);
        chk("rst1_redir", {31'd0, Redirecting}, 32'd0);
        chk("rst1_flush", {30'd0, IFIDFlush, IDEXFlush}, 32'd0);
        tick();
        chk("rst2_pc", PC, 32'h3000);
        rst = 1'b0;
        #1;
        chk("boot_fv", {31'd0, FetchValid}, 32'd0);
        tick();
        chk("run0_pc", PC, 32'h3000);
        chk("run0_fv", {31'd0, FetchValid}, 32'd1);
        tick(); chk("run1_pc", PC, 32'h3004);
        tick(); chk("run2_pc", PC, 32'h3008);
        tick(); chk("run3_pc", PC, 32'h300C);
        tick(); chk("run4_pc", PC, 32'h3010);

        // mispredict
        NextType = 2'b01; IDEXPC4 = 32'h3008;
        #1;
        chk("mis_ifid", {31'd0, IFIDFlush}, 32'd1);
        chk("mis_idex", {31'd0, IDEXFlush}, 32'd1);
        tick();
        NextType = 2'b00;
        #1;
        chk("mis_pc", PC, 32'h3008);
        chk("mis_redir", {31'd0, Redirecting}, 32'd1);
        chk("mis_cnt", {24'd0, MispredictCnt}, 32'd1);
        tick();
        chk("mis_after_pc", PC, 32'h300C);
        chk("mis_after_redir", {31'd0, Redirecting}, 32'd0);

        // jump held two cycles
        NextType = 2'b10; JumpPC = 32'h3100;
        #1;
        chk("jmp_flush", {31'd0, IFIDFlush}, 32'd1);
        tick();
        chk("jmp_pc", PC, 32'h3100);
        chk("jmp_redir_noflush", {30'd0, IFIDFlush, IDEXFlush}, 32'd0);
        tick();
        NextType = 2'b00;
        #1;
        chk("jmp_pc2", PC, 32'h3104);
        chk("jmp_cnt", {24'd0, JumpCnt}, 32'd1);

        // stall over prediction
        Stall = 1'b1; BranchPredTaken = 1'b1; BranchTarget = 32'h3040;
        tick(); chk("stall1_pc", PC, 32'h3104);
        tick(); chk("stall2_pc", PC, 32'h3104);
        Stall = 1'b0;
        tick(); chk("pred_pc", PC, 32'h3040);
        BranchPredTaken = 1'b0;
        tick(); chk("pred_next_pc", PC, 32'h3044);

        // redirect over stall
        Stall = 1'b1; NextType = 2'b01; IDEXPC4 = 32'h3200;
        #1;
        chk("stallmis_flush", {30'd0, IFIDFlush, IDEXFlush}, 32'd3);
        tick();
        NextType = 2'b00;
        #1;
        chk("stallmis_pc", PC, 32'h3200);
        chk("stallmis_cnt", {24'd0, MispredictCnt}, 32'd2);
        tick(); chk("redir_stall_pc", PC, 32'h3200);
        Stall = 1'b0;
        tick(); chk("redir_stall_rel_pc", PC, 32'h3204);

        // wraparound
        NextType = 2'b10; JumpPC = 32'hFFFF_FFFC;
        tick();
        NextType = 2'b00;
        #1;
        chk("wrap_pc0", PC, 32'hFFFF_FFFC);
        chk("wrap_jcnt", {24'd0, JumpCnt}, 32'd2);
        tick(); chk("wrap_pc1", PC, 32'h0000_0000);

        // reserved NextType acts as PC+4
        NextType = 2'b11;
        #1;
        chk("rsvd_flush", {30'd0, IFIDFlush, IDEXFlush}, 32'd0);
        tick(); chk("rsvd_pc", PC, 32'h0000_0004);
        chk("rsvd_cnts", {16'd0, MispredictCnt, JumpCnt}, {16'd0, 8'd2, 8'd2});
        NextType = 2'b00;

        // reset in REDIR
        NextType = 2'b10; JumpPC = 32'h3300;
        tick();
        NextType = 2'b00;
        #1;
        chk("pre_rst_redir", {31'd0, Redirecting}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_pc", PC, 32'h3000);
        chk("midrst_mcnt", {24'd0, MispredictCnt}, 32'd0);
        chk("midrst_jcnt", {24'd0, JumpCnt}, 32'd0);
        chk("midrst_redir", {31'd0, Redirecting}, 32'd0);
        chk("midrst_fv", {31'd0, FetchValid}, 32'd0);
        tick();
        chk("midrst_run_pc", PC, 32'h3000);

        // saturation: held mispredict is accepted every other cycle
        NextType = 2'b01; IDEXPC4 = 32'h3000;
        for (int i = 0; i < 254 * 2; i++) tick();
        chk("sat_254", {24'd0, MispredictCnt}, 32'd254);
        for (int i = 0; i < 3 * 2; i++) tick();
        NextType = 2'b00;
        #1;
        chk("sat_max", {24'd0, MispredictCnt}, 32'h0000_00FF);
        chk("sat_jcnt", {24'd0, JumpCnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
